// File: rtl/rv32i_encoder_if.sv
// Field/handshake bundle between an instruction source and rv32i_encoder, plus the
// one-hot bit positions shared with the decoder. i_muldiv exists only when RV32M_EN is defined.
`ifndef RV32I_ENC_DEFS
`define RV32I_ENC_DEFS
`define OPCODE_WIDTH   9
`define ENC_OP_RTYPE   0
`define ENC_OP_ITYPE   1
`define ENC_OP_LOAD    2
`define ENC_OP_STORE   3
`define ENC_OP_BRANCH  4
`define ENC_OP_JAL     5
`define ENC_OP_JALR    6
`define ENC_OP_LUI     7
`define ENC_OP_AUIPC   8
`define ALU_WIDTH      14
`define ENC_ALU_ADD    0
`define ENC_ALU_SUB    1
`define ENC_ALU_SLL    2
`define ENC_ALU_SLT    3
`define ENC_ALU_SLTU   4
`define ENC_ALU_XOR    5
`define ENC_ALU_SRL    6
`define ENC_ALU_SRA    7
`define ENC_ALU_OR     8
`define ENC_ALU_AND    9
`define ENC_ALU_EQ     10
`define ENC_ALU_NEQ    11
`define ENC_ALU_GE     12
`define ENC_ALU_GEU    13
`endif

interface rv32i_encoder_if;
    logic                     i_valid;
    logic                     o_ready;
    logic [`OPCODE_WIDTH-1:0] i_opcode;
    logic [`ALU_WIDTH-1:0]    i_alu_op;
    logic [2:0]               i_mem_funct3;
    logic [4:0]               i_rs1_addr;
    logic [4:0]               i_rs2_addr;
    logic [4:0]               i_rd_addr;
    logic [31:0]              i_imm;
`ifdef RV32M_EN
    logic [7:0]               i_muldiv;
`endif
    logic                     o_valid;
    logic                     i_ready;
    logic [31:0]              o_inst;
    logic [31:0]              o_addr;

    modport master (
`ifdef RV32M_EN
        output i_muldiv,
`endif
        output i_valid, i_opcode, i_alu_op, i_mem_funct3, i_rs1_addr, i_rs2_addr,
        output i_rd_addr, i_imm, i_ready,
        input  o_ready, o_valid, o_inst, o_addr
    );

    modport slave (
`ifdef RV32M_EN
        input  i_muldiv,
`endif
        input  i_valid, i_opcode, i_alu_op, i_mem_funct3, i_rs1_addr, i_rs2_addr,
        input  i_rd_addr, i_imm, i_ready,
        output o_ready, o_valid, o_inst, o_addr
    );
endinterface

// File: rtl/rv32i_encoder.sv
// Single-stage RV32I encoder: one-hot decoded fields in, instruction word and IMEM address out.
// Define RV32M_EN to add MUL/DIV encoding through i_muldiv.
module rv32i_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_encoder_if.slave       bus,
    input  logic                 i_clear,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    logic [`OPCODE_WIDTH-1:0] op;
    logic [`ALU_WIDTH-1:0]    alu;
    logic [31:0]              imm;
    logic [4:0]               rs1, rs2, rd;
    logic [2:0]               mem_f3;

    assign op     = bus.i_opcode;
    assign alu    = bus.i_alu_op;
    assign imm    = bus.i_imm;
    assign rs1    = bus.i_rs1_addr;
    assign rs2    = bus.i_rs2_addr;
    assign rd     = bus.i_rd_addr;
    assign mem_f3 = bus.i_mem_funct3;

    logic valid_reg, valid_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] addr_reg, addr_next;
    logic err_reg, err_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;

    logic ready, accept, xfer;
    assign ready  = !valid_reg || bus.i_ready;
    assign accept = bus.i_valid && ready;
    assign xfer   = valid_reg && bus.i_ready;

    logic op_onehot, alu_onehot;
    assign op_onehot  = (op != '0) && ((op & (op - `OPCODE_WIDTH'(1))) == '0);
    assign alu_onehot = (alu != '0) && ((alu & (alu - `ALU_WIDTH'(1))) == '0);

    // With alu one-hot, each funct3 bit is the OR of the ops that set it.
    logic [2:0] alu_f3, br_f3;
    logic r_ok, i_ok, br_ok, alt, shift;
    assign alu_f3[2] = alu[`ENC_ALU_XOR] | alu[`ENC_ALU_SRL] | alu[`ENC_ALU_SRA] |
                       alu[`ENC_ALU_OR]  | alu[`ENC_ALU_AND];
    assign alu_f3[1] = alu[`ENC_ALU_SLT] | alu[`ENC_ALU_SLTU] | alu[`ENC_ALU_OR] | alu[`ENC_ALU_AND];
    assign alu_f3[0] = alu[`ENC_ALU_SLL] | alu[`ENC_ALU_SLTU] | alu[`ENC_ALU_SRL] |
                       alu[`ENC_ALU_SRA] | alu[`ENC_ALU_AND];
    assign r_ok  = |alu[`ENC_ALU_AND:`ENC_ALU_ADD];
    assign i_ok  = r_ok && !alu[`ENC_ALU_SUB];
    assign alt   = alu[`ENC_ALU_SUB] | alu[`ENC_ALU_SRA];
    assign shift = alu[`ENC_ALU_SLL] | alu[`ENC_ALU_SRL] | alu[`ENC_ALU_SRA];

    assign br_f3[2] = alu[`ENC_ALU_SLT] | alu[`ENC_ALU_GE] | alu[`ENC_ALU_SLTU] | alu[`ENC_ALU_GEU];
    assign br_f3[1] = alu[`ENC_ALU_SLTU] | alu[`ENC_ALU_GEU];
    assign br_f3[0] = alu[`ENC_ALU_NEQ] | alu[`ENC_ALU_GE] | alu[`ENC_ALU_GEU];
    assign br_ok    = alu[`ENC_ALU_EQ] | alu[`ENC_ALU_NEQ] | alu[`ENC_ALU_SLT] |
                      alu[`ENC_ALU_GE] | alu[`ENC_ALU_SLTU] | alu[`ENC_ALU_GEU];

    // Immediate fits when every bit above the format's sign bit equals the sign bit.
    logic fits12, fits13, fits21;
    assign fits12 = (&imm[31:11]) || (imm[31:11] == '0);
    assign fits13 = (&imm[31:12]) || (imm[31:12] == '0);
    assign fits21 = (&imm[31:20]) || (imm[31:20] == '0);

`ifdef RV32M_EN
    logic [7:0] md;
    logic [2:0] md_f3;
    logic       md_onehot;
    assign md        = bus.i_muldiv;
    assign md_onehot = (md != '0) && ((md & (md - 8'd1)) == '0);
    always_comb begin
        md_f3 = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (md[k]) md_f3 = 3'(k);
        end
    end
`endif

    logic [31:0] inst_enc;
    logic        legal;

    always_comb begin
        inst_enc = '0;
        legal    = 1'b0;
        if (op[`ENC_OP_RTYPE]) begin
            inst_enc = {1'b0, alt, 5'b0, rs2, rs1, alu_f3, rd, 7'b0110011};
            legal    = alu_onehot && r_ok;
        end else if (op[`ENC_OP_ITYPE]) begin
            if (shift) begin
                inst_enc = {1'b0, alt, 5'b0, imm[4:0], rs1, alu_f3, rd, 7'b0010011};
                legal    = alu_onehot && (imm[31:5] == '0);
            end else begin
                inst_enc = {imm[11:0], rs1, alu_f3, rd, 7'b0010011};
                legal    = alu_onehot && i_ok && fits12;
            end
        end else if (op[`ENC_OP_LOAD]) begin
            inst_enc = {imm[11:0], rs1, mem_f3, rd, 7'b0000011};
            legal    = fits12;
        end else if (op[`ENC_OP_JALR]) begin
            inst_enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            legal    = fits12;
        end else if (op[`ENC_OP_STORE]) begin
            inst_enc = {imm[11:5], rs2, rs1, mem_f3, imm[4:0], 7'b0100011};
            legal    = fits12;
        end else if (op[`ENC_OP_BRANCH]) begin
            inst_enc = {imm[12], imm[10:5], rs2, rs1, br_f3, imm[4:1], imm[11], 7'b1100011};
            legal    = alu_onehot && br_ok && fits13 && !imm[0];
        end else if (op[`ENC_OP_JAL]) begin
            inst_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            legal    = fits21 && !imm[0];
        end else if (op[`ENC_OP_LUI]) begin
            inst_enc = {imm[31:12], rd, 7'b0110111};
            legal    = (imm[11:0] == '0);
        end else if (op[`ENC_OP_AUIPC]) begin
            inst_enc = {imm[31:12], rd, 7'b0010111};
            legal    = (imm[11:0] == '0);
        end
`ifdef RV32M_EN
        if (md != '0) begin
            inst_enc = {7'b0000001, rs2, rs1, md_f3, rd, 7'b0110011};
            legal    = op[`ENC_OP_RTYPE] && md_onehot;
        end
`endif
        if (!op_onehot) legal = 1'b0;
    end

    always_comb begin
        valid_next   = valid_reg;
        inst_next    = inst_reg;
        addr_next    = addr_reg;
        err_next     = 1'b0;
        err_cnt_next = err_cnt_reg;
        if (xfer) valid_next = 1'b0;
        if (accept) begin
            if (legal) begin
                valid_next = 1'b1;
                inst_next  = inst_enc;
            end else begin
                err_next = 1'b1;
                if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
            end
        end
        // A clear in the same cycle as a transfer still restarts at the base address.
        if (i_clear)   addr_next = BASE_ADDR;
        else if (xfer) addr_next = addr_reg + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            inst_reg    <= '0;
            addr_reg    <= BASE_ADDR;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            valid_reg   <= valid_next;
            inst_reg    <= inst_next;
            addr_reg    <= addr_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = valid_reg;
    assign bus.o_inst  = inst_reg;
    assign bus.o_addr  = addr_reg;
    assign o_err       = err_reg;
    assign o_err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_rv32i_encoder.sv
// Directed-vector bench for rv32i_encoder: encodes, rejects, saturation, backpressure,
// clear, reset and (when RV32M_EN is defined) multiply/divide encodes.
`timescale 1ns/1ps
`ifndef RV32I_ENC_DEFS
`define RV32I_ENC_DEFS
`define OPCODE_WIDTH   9
`define ENC_OP_RTYPE   0
`define ENC_OP_ITYPE   1
`define ENC_OP_LOAD    2
`define ENC_OP_STORE   3
`define ENC_OP_BRANCH  4
`define ENC_OP_JAL     5
`define ENC_OP_JALR    6
`define ENC_OP_LUI     7
`define ENC_OP_AUIPC   8
`define ALU_WIDTH      14
`define ENC_ALU_ADD    0
`define ENC_ALU_SUB    1
`define ENC_ALU_SLL    2
`define ENC_ALU_SLT    3
`define ENC_ALU_SLTU   4
`define ENC_ALU_XOR    5
`define ENC_ALU_SRL    6
`define ENC_ALU_SRA    7
`define ENC_ALU_OR     8
`define ENC_ALU_AND    9
`define ENC_ALU_EQ     10
`define ENC_ALU_NEQ    11
`define ENC_ALU_GE     12
`define ENC_ALU_GEU    13
`endif

module tb_rv32i_encoder;
    localparam int OW = `OPCODE_WIDTH;
    localparam int AW = `ALU_WIDTH;

    localparam logic [OW-1:0] OP_R    = OW'(1) << `ENC_OP_RTYPE;
    localparam logic [OW-1:0] OP_I    = OW'(1) << `ENC_OP_ITYPE;
    localparam logic [OW-1:0] OP_LD   = OW'(1) << `ENC_OP_LOAD;
    localparam logic [OW-1:0] OP_S    = OW'(1) << `ENC_OP_STORE;
    localparam logic [OW-1:0] OP_B    = OW'(1) << `ENC_OP_BRANCH;
    localparam logic [OW-1:0] OP_JAL  = OW'(1) << `ENC_OP_JAL;
    localparam logic [OW-1:0] OP_JALR = OW'(1) << `ENC_OP_JALR;
    localparam logic [OW-1:0] OP_LUI  = OW'(1) << `ENC_OP_LUI;

    localparam logic [AW-1:0] A_ADD = AW'(1) << `ENC_ALU_ADD;
    localparam logic [AW-1:0] A_SUB = AW'(1) << `ENC_ALU_SUB;
    localparam logic [AW-1:0] A_SLL = AW'(1) << `ENC_ALU_SLL;
    localparam logic [AW-1:0] A_XOR = AW'(1) << `ENC_ALU_XOR;
    localparam logic [AW-1:0] A_SRA = AW'(1) << `ENC_ALU_SRA;
    localparam logic [AW-1:0] A_AND = AW'(1) << `ENC_ALU_AND;
    localparam logic [AW-1:0] A_EQ  = AW'(1) << `ENC_ALU_EQ;
    localparam logic [AW-1:0] A_NEQ = AW'(1) << `ENC_ALU_NEQ;
    localparam logic [AW-1:0] A_GE  = AW'(1) << `ENC_ALU_GE;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_clear;
    logic       o_err;
    logic [7:0] o_err_cnt;
    int         errors = 0;
    int         checks = 0;

    rv32i_encoder_if bus();

    rv32i_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .i_clear   (i_clear),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );

    always #5 clk = ~clk;

    localparam int NENC = 13;
    logic [OW-1:0] enc_op  [NENC] = '{OP_I, OP_R, OP_LUI, OP_I, OP_S, OP_JAL, OP_R, OP_LD,
                                      OP_JALR, OP_B, OP_B, OP_I, OP_B};
    logic [AW-1:0] enc_alu [NENC] = '{A_ADD, A_SUB, '0, A_SRA, '0, '0, A_AND, '0,
                                      A_ADD | A_XOR, A_EQ, A_GE, A_ADD, A_EQ};
    logic [2:0]    enc_f3  [NENC] = '{0, 0, 0, 0, 2, 0, 0, 2, 7, 0, 0, 0, 0};
    logic [4:0]    enc_rs1 [NENC] = '{2, 1, 0, 2, 1, 0, 6, 2, 1, 1, 1, 0, 0};
    logic [4:0]    enc_rs2 [NENC] = '{0, 2, 0, 0, 2, 0, 7, 0, 0, 2, 2, 0, 0};
    logic [4:0]    enc_rd  [NENC] = '{1, 3, 5, 1, 31, 1, 5, 1, 0, 31, 0, 1, 0};
    logic [31:0]   enc_imm [NENC] = '{32'hFFFFFFFF, 32'hDEADBEEF, 32'h12345000, 32'd3, 32'd8,
                                      32'd8, 32'd0, 32'hFFFFFFFC, 32'd0, 32'd8, 32'hFFFFFFFC,
                                      32'h7FF, 32'hFFFFF000};
    logic [31:0]   enc_exp [NENC] = '{32'hFFF10093, 32'h402081B3, 32'h123452B7, 32'h40315093,
                                      32'h0020A423, 32'h008000EF, 32'h007372B3, 32'hFFC12083,
                                      32'h00008067, 32'h00208463, 32'hFE20DEE3, 32'h7FF00093,
                                      32'h80000063};

    localparam int NREJ = 16;
    logic [OW-1:0] rej_op  [NREJ] = '{OP_B, OP_I, OP_R | OP_I, OP_I, OP_I, OP_B, OP_R, OP_JAL,
                                      OP_JAL, OP_LUI, OP_S, OP_B, '0, OP_R, OP_LD, OP_B};
    logic [AW-1:0] rej_alu [NREJ] = '{A_EQ, A_ADD, A_ADD, A_SLL, A_SUB, A_ADD, A_ADD | A_XOR, '0,
                                      '0, '0, '0, A_EQ, A_ADD, '0, '0, A_EQ | A_NEQ};
    logic [31:0]   rej_imm [NREJ] = '{32'd9, 32'h800, 32'd0, 32'd32, 32'd0, 32'd8, 32'd0, 32'd9,
                                      32'h100000, 32'h12345001, 32'hFFFFF7FF, 32'h1000, 32'd0,
                                      32'd0, 32'h800, 32'd8};

    task automatic drive(input logic [OW-1:0] op, input logic [AW-1:0] alu, input logic [2:0] f3,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm);
        bus.i_opcode     = op;
        bus.i_alu_op     = alu;
        bus.i_mem_funct3 = f3;
        bus.i_rs1_addr   = rs1;
        bus.i_rs2_addr   = rs2;
        bus.i_rd_addr    = rd;
        bus.i_imm        = imm;
    endtask

    // Presents one input for a single cycle; returns at the negedge where its result is visible.
    task automatic send(input logic [OW-1:0] op, input logic [AW-1:0] alu, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm);
        @(negedge clk);
        drive(op, alu, f3, rs1, rs2, rd, imm);
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        i_clear     = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        drive('0, '0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
`ifdef RV32M_EN
        bus.i_muldiv = '0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", bus.o_inst); end
        checks++; if (bus.o_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", bus.o_addr); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
        checks++; if (o_err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %h expected 00", o_err_cnt); end
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready); end
        rst = 1'b0;
    endtask

    task automatic test_encode;
        for (int k = 0; k < NENC; k++) begin
            send(enc_op[k], enc_alu[k], enc_f3[k], enc_rs1[k], enc_rs2[k], enc_rd[k], enc_imm[k]);
            $display("encode[%0d]: inst=%h addr=%h valid=%b", k, bus.o_inst, bus.o_addr, bus.o_valid);
            checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL enc_valid[%0d]: got %b expected 1", k, bus.o_valid); end
            checks++; if (bus.o_inst !== enc_exp[k]) begin errors++; $display("FAIL enc_inst[%0d]: got %h expected %h", k, bus.o_inst, enc_exp[k]); end
            checks++; if (bus.o_addr !== 32'(4 * k)) begin errors++; $display("FAIL enc_addr[%0d]: got %h expected %h", k, bus.o_addr, 32'(4 * k)); end
            checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL enc_err[%0d]: got %b expected 0", k, o_err); end
        end
    endtask

    task automatic test_reject;
        for (int k = 0; k < NREJ; k++) begin
            send(rej_op[k], rej_alu[k], 3'd0, 5'd1, 5'd2, 5'd3, rej_imm[k]);
            $display("reject[%0d]: err=%b cnt=%0d valid=%b", k, o_err, o_err_cnt, bus.o_valid);
            checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL rej_err[%0d]: got %b expected 1", k, o_err); end
            checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rej_valid[%0d]: got %b expected 0", k, bus.o_valid); end
            checks++; if (o_err_cnt !== 8'(k + 1)) begin errors++; $display("FAIL rej_cnt[%0d]: got %0d expected %0d", k, o_err_cnt, k + 1); end
            checks++; if (bus.o_addr !== 32'h34) begin errors++; $display("FAIL rej_addr[%0d]: got %h expected 00000034", k, bus.o_addr); end
            @(negedge clk);
            checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rej_err_pulse[%0d]: got %b expected 0", k, o_err); end
        end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        drive('0, A_ADD, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        bus.i_valid = 1'b1;
        repeat (100) @(negedge clk);
        $display("saturation: cnt=%0d after 100 more rejects", o_err_cnt);
        checks++; if (o_err_cnt !== 8'd116) begin errors++; $display("FAIL sat_mid: got %0d expected 116", o_err_cnt); end
        repeat (200) @(negedge clk);
        bus.i_valid = 1'b0;
        $display("saturation: cnt=%0d after 300 more rejects", o_err_cnt);
        checks++; if (o_err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_cnt: got %h expected ff", o_err_cnt); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL sat_err: got %b expected 1", o_err); end
        @(negedge clk);
        checks++; if (o_err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h expected ff", o_err_cnt); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL sat_err_drop: got %b expected 0", o_err); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        checks++; if (bus.o_addr !== 32'h34) begin errors++; $display("FAIL bp_pre_addr: got %h expected 00000034", bus.o_addr); end
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        checks++; if (bus.o_addr !== 32'h0) begin errors++; $display("FAIL bp_clear_addr: got %h expected 00000000", bus.o_addr); end
        bus.i_ready = 1'b0;
        drive(OP_I, A_ADD, 3'd0, 5'd0, 5'd0, 5'd1, 32'd1);
        bus.i_valid = 1'b1;
        @(negedge clk);
        drive(OP_I, A_ADD, 3'd0, 5'd0, 5'd0, 5'd1, 32'd2);
        for (int c = 0; c < 4; c++) begin
            $display("stall[%0d]: inst=%h addr=%h ready=%b", c, bus.o_inst, bus.o_addr, bus.o_ready);
            checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, bus.o_valid); end
            checks++; if (bus.o_inst !== 32'h00100093) begin errors++; $display("FAIL bp_inst[%0d]: got %h expected 00100093", c, bus.o_inst); end
            checks++; if (bus.o_addr !== 32'h0) begin errors++; $display("FAIL bp_addr[%0d]: got %h expected 00000000", c, bus.o_addr); end
            checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", c, bus.o_ready); end
            if (c < 3) @(negedge clk);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        drive(OP_I, A_ADD, 3'd0, 5'd0, 5'd0, 5'd1, 32'd3);
        $display("release[1]: inst=%h addr=%h", bus.o_inst, bus.o_addr);
        checks++; if (bus.o_inst !== 32'h00200093) begin errors++; $display("FAIL bp_rel1_inst: got %h expected 00200093", bus.o_inst); end
        checks++; if (bus.o_addr !== 32'h4) begin errors++; $display("FAIL bp_rel1_addr: got %h expected 00000004", bus.o_addr); end
        @(negedge clk);
        bus.i_valid = 1'b0;
        $display("release[2]: inst=%h addr=%h", bus.o_inst, bus.o_addr);
        checks++; if (bus.o_inst !== 32'h00300093) begin errors++; $display("FAIL bp_rel2_inst: got %h expected 00300093", bus.o_inst); end
        checks++; if (bus.o_addr !== 32'h8) begin errors++; $display("FAIL bp_rel2_addr: got %h expected 00000008", bus.o_addr); end
        @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_addr !== 32'hC) begin errors++; $display("FAIL bp_drain_addr: got %h expected 0000000c", bus.o_addr); end
    endtask

    task automatic test_clear;
        send(OP_I, A_ADD, 3'd0, 5'd0, 5'd0, 5'd1, 32'd7);
        checks++; if (bus.o_addr !== 32'hC) begin errors++; $display("FAIL clr_pre_addr: got %h expected 0000000c", bus.o_addr); end
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        $display("clear+transfer: valid=%b addr=%h", bus.o_valid, bus.o_addr);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL clr_xfer_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_addr !== 32'h0) begin errors++; $display("FAIL clr_wins_addr: got %h expected 00000000", bus.o_addr); end
        bus.i_ready = 1'b0;
        send(OP_I, A_ADD, 3'd0, 5'd0, 5'd0, 5'd1, 32'd9);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        $display("clear while stalled: valid=%b inst=%h", bus.o_valid, bus.o_inst);
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL clr_keeps_valid: got %b expected 1", bus.o_valid); end
        checks++; if (bus.o_inst !== 32'h00900093) begin errors++; $display("FAIL clr_keeps_inst: got %h expected 00900093", bus.o_inst); end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1;
        @(negedge clk);
        $display("reset mid-handshake: valid=%b inst=%h cnt=%0d", bus.o_valid, bus.o_inst, o_err_cnt);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_inst !== 32'h0) begin errors++; $display("FAIL rstmid_inst: got %h expected 00000000", bus.o_inst); end
        checks++; if (o_err_cnt !== 8'h00) begin errors++; $display("FAIL rstmid_cnt: got %h expected 00", o_err_cnt); end
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", bus.o_ready); end
        rst = 1'b0;
        bus.i_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_inst [3] = '{32'h00400113, 32'h00500113, 32'h00600113};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                $display("b2b[%0d]: inst=%h addr=%h", k - 1, bus.o_inst, bus.o_addr);
                checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k - 1, bus.o_valid); end
                checks++; if (bus.o_inst !== exp_inst[k - 1]) begin errors++; $display("FAIL b2b_inst[%0d]: got %h expected %h", k - 1, bus.o_inst, exp_inst[k - 1]); end
                checks++; if (bus.o_addr !== 32'(4 * (k - 1))) begin errors++; $display("FAIL b2b_addr[%0d]: got %h expected %h", k - 1, bus.o_addr, 32'(4 * (k - 1))); end
            end
            if (k < 3) begin
                drive(OP_I, A_ADD, 3'd0, 5'd0, 5'd0, 5'd2, 32'(k + 4));
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", bus.o_valid); end
    endtask

`ifdef RV32M_EN
    task automatic test_rv32m;
        bus.i_muldiv = 8'b0000_0001;
        send(OP_R, '0, 3'd0, 5'd2, 5'd3, 5'd1, 32'd0);
        $display("mul: inst=%h addr=%h", bus.o_inst, bus.o_addr);
        checks++; if (bus.o_inst !== 32'h023100B3) begin errors++; $display("FAIL m_mul_inst: got %h expected 023100b3", bus.o_inst); end
        checks++; if (bus.o_addr !== 32'hC) begin errors++; $display("FAIL m_mul_addr: got %h expected 0000000c", bus.o_addr); end
        send(OP_I, A_ADD, 3'd0, 5'd2, 5'd3, 5'd1, 32'd0);
        checks++; if (o_err !== 1'b1 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL m_itype_reject: got err=%b valid=%b expected err=1 valid=0", o_err, bus.o_valid); end
        checks++; if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL m_itype_cnt: got %0d expected 1", o_err_cnt); end
        bus.i_muldiv = 8'b0010_0000;
        send(OP_R, A_SUB, 3'd0, 5'd2, 5'd3, 5'd1, 32'd0);
        $display("divu: inst=%h addr=%h", bus.o_inst, bus.o_addr);
        checks++; if (bus.o_inst !== 32'h023150B3) begin errors++; $display("FAIL m_divu_inst: got %h expected 023150b3", bus.o_inst); end
        checks++; if (bus.o_addr !== 32'h10) begin errors++; $display("FAIL m_divu_addr: got %h expected 00000010", bus.o_addr); end
        bus.i_muldiv = 8'b0000_0011;
        send(OP_R, '0, 3'd0, 5'd2, 5'd3, 5'd1, 32'd0);
        checks++; if (o_err_cnt !== 8'd2 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL m_twohot: got cnt=%0d valid=%b expected cnt=2 valid=0", o_err_cnt, bus.o_valid); end
        bus.i_muldiv = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_encode();
        test_reject();
        test_saturation();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_back_to_back();
`ifdef RV32M_EN
        test_rv32m();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
